// File: rtl/rca_acc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rca_acc_pkg                                                              |
// | Shared constants, FSM state type and saturating-increment helper for    |
// | the rca_acc_16 accumulator and its ripple-carry adder datapath.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rca_acc_pkg;

  // Operand/sum width, tied to the downstream ripple-carry adder.
  localparam int WIDTH = 16;
  // Width of the operand counter and carry counter.
  localparam int CNT_W = 8;
  // Saturation ceiling shared by both counters.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ACC  = 1'b0,  // accepting operands
    DONE = 1'b1   // holding a result for the consumer
  } state_t;

  // Adds inc to v, sticking at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_acc_16_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rca_acc_16_if                                                            |
// | Operand stream (valid/ready/last) and result port (valid/ready) for     |
// | rca_acc_16.                                                              |
// |   master : source of operands, consumer of results                       |
// |   slave  : the accumulator                                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface rca_acc_16_if;
  import rca_acc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_carries;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carries, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carries, out_count, out_ovf
  );

endinterface
`default_nettype wire

// File: rtl/rca_16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rca_16                                                                   |
// | Combinational N-bit ripple-carry adder: {co, s} = x + y + cin.          |
// |   x, y : operands      cin : carry in                                    |
// |   s    : sum           co  : carry out of the MSB                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rca_16
  import rca_acc_pkg::*;
#(
  parameter int N = WIDTH
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[N];

endmodule
`default_nettype wire

// File: rtl/rca_acc_16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rca_acc_16                                                               |
// | Packet accumulator behind a 16-bit ripple-carry adder. Sums each packet |
// | modulo 2^16, counts adder carry-outs and operands (both saturating) and |
// | offers the result on a valid/ready port.                                |
// |   clk   : rising-edge clock                                              |
// |   rst_n : synchronous active-low reset                                   |
// |   bus   : operand stream in, result out (rca_acc_16_if.slave)            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rca_acc_16
  import rca_acc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  rca_acc_16_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  logic             in_ready;
  logic             accept;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic [CNT_W-1:0] carry_cnt;
  logic [CNT_W-1:0] op_cnt;
  logic [CNT_W-1:0] carry_nxt;
  logic [CNT_W-1:0] op_nxt;

  logic             out_valid;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_carries;
  logic [CNT_W-1:0] out_count;

  // Single combinational adder path; no carry-in on this accumulator.
  rca_16 #(.N(WIDTH)) u_rca (
    .x   (acc),
    .y   (bus.in_data),
    .cin (1'b0),
    .s   (sum),
    .co  (co)
  );

  assign accept    = bus.in_valid && in_ready;
  assign carry_nxt = sat_inc(carry_cnt, co);
  assign op_nxt    = sat_inc(op_cnt, 1'b1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && bus.in_last) state_nxt = DONE;
      DONE:    if (bus.out_ready)         state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Output logic. rst_n gates in_ready so no beat is taken during reset.
  always_comb begin
    in_ready = (state == ACC) && rst_n;
  end

  // Accumulator, counters and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc         <= '0;
      carry_cnt   <= '0;
      op_cnt      <= '0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_carries <= '0;
      out_count   <= '0;
    end else if (accept) begin
      if (bus.in_last) begin
        // Publish the packet total and clear for the next packet on the
        // same edge.
        out_sum     <= sum;
        out_carries <= carry_nxt;
        out_count   <= op_nxt;
        out_valid   <= 1'b1;
        acc         <= '0;
        carry_cnt   <= '0;
        op_cnt      <= '0;
      end else begin
        acc         <= sum;
        carry_cnt   <= carry_nxt;
        op_cnt      <= op_nxt;
      end
    end else if ((state == DONE) && bus.out_ready) begin
      // Result data registers keep their values; only out_valid drops.
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_sum     = out_sum;
  assign bus.out_carries = out_carries;
  assign bus.out_count   = out_count;
  assign bus.out_ovf     = |out_carries;

endmodule
`default_nettype wire

// File: tb/tb_rca_acc_16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rca_acc_16                                                            |
// | Self-checking bench for rca_acc_16: directed packets push expected      |
// | results into a queue; a monitor pops and compares on every result       |
// | handshake.                                                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rca_acc_16;
  import rca_acc_pkg::*;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] carries;
    logic [CNT_W-1:0] count;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   rand_ready  = 1'b0;
  logic force_ready = 1'b1;

  always #5 clk = ~clk;

  rca_acc_16_if bus ();

  rca_acc_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer ready: driven late in the cycle so the main process settles first.
  always @(posedge clk) begin
    #2;
    bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
  end

  // Monitor: a result is consumed whenever valid and ready are both high.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got sum 0x%0h, expected no result", bus.out_sum);
      end else begin
        e = sb.pop_front();
        chk("out_sum",     32'(bus.out_sum),     32'(e.sum));
        chk("out_carries", 32'(bus.out_carries), 32'(e.carries));
        chk("out_count",   32'(bus.out_count),   32'(e.count));
        chk("out_ovf",     32'(bus.out_ovf),     32'(e.carries != 0));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got in_ready 0 for 200 cycles, expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin : main
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] c;
    logic [CNT_W-1:0] k;
    logic [WIDTH:0]   t;
    int               len;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
    chk("rst_in_ready",    32'(bus.in_ready),    32'd0);
    chk("rst_out_sum",     32'(bus.out_sum),     32'd0);
    chk("rst_out_count",   32'(bus.out_count),   32'd0);
    chk("rst_out_carries", 32'(bus.out_carries), 32'd0);
    chk("rst_out_ovf",     32'(bus.out_ovf),     32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: simple packet, one-cycle latency
    sb.push_back('{sum: 16'h0006, carries: 8'd0, count: 8'd3});
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b1);
    @(negedge clk);
    chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    wait_drain();

    // 2: wrap-around and carries
    sb.push_back('{sum: 16'h0000, carries: 8'd2, count: 8'd4});
    send(16'hFFFF, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h8000, 1'b0);
    send(16'h8000, 1'b1);
    wait_drain();

    // 3: single-beat packet with consumer stall
    repeat (2) @(posedge clk);
    #1 force_ready = 1'b0;
    sb.push_back('{sum: 16'h1234, carries: 8'd0, count: 8'd1});
    send(16'h1234, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out_sum",   32'(bus.out_sum),   32'h1234);
      chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
    end
    @(posedge clk);
    #1 force_ready = 1'b1;
    @(negedge clk);
    chk("handoff_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("bubble_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    wait_drain();

    // 4: count saturation over 300 beats
    sb.push_back('{sum: 16'h012C, carries: 8'd0, count: 8'd255});
    for (int i = 0; i < 300; i++) send(16'h0001, (i == 299));
    wait_drain();

    // 5: reset mid-packet
    send(16'h0007, 1'b0);
    send(16'h0009, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_sum",   32'(bus.out_sum),   32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.push_back('{sum: 16'h0005, carries: 8'd0, count: 8'd1});
    send(16'h0005, 1'b1);
    wait_drain();

    // 6: back-to-back packets, random gaps and consumer stalls
    rand_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 6);
      s = '0;
      c = '0;
      k = '0;
      for (int b = 0; b < len; b++) begin
        logic [WIDTH-1:0] d;
        d = WIDTH'($urandom);
        if (b == 1 || b == 3) d = 16'hF000 | d;  // make carries likely
        t = {1'b0, s} + {1'b0, d};
        s = t[WIDTH-1:0];
        if (t[WIDTH] && c != 8'hFF) c = c + 8'd1;
        if (k != 8'hFF) k = k + 8'd1;
        if (b == len - 1) sb.push_back('{sum: s, carries: c, count: k});
        // Idle gap with junk data and a stray in_last that must be ignored.
        if ($urandom_range(0, 2) == 0) begin
          bus.in_data = WIDTH'($urandom);
          bus.in_last = 1'b1;
          @(posedge clk);
          #1 bus.in_last = 1'b0;
        end
        send(d, (b == len - 1));
      end
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
